// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the interrupt controller
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [15:0] VEC_BASE_DEFAULT = 16'h00F0;
    localparam logic [5:0]  RETI_OPCODE      = 6'b011111;

endpackage

// File: rtl/prio_enc4.sv
// rtl/prio_enc4.sv - 4-to-2 lowest-index-wins priority encoder
module prio_enc4 (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else if (req[3]) idx = 2'd3;
        else             valid = 1'b0;
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-latched, masked, fixed-priority non-nesting interrupt controller
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC    = 4,
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             jmp_busy,
    input  logic             reti,
    output logic             interrupt,
    output logic [15:0]      isr_vector,
    output logic             in_service,
    output logic [1:0]       active_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);

    state_t           state;
    state_t           state_next;
    logic [N_SRC-1:0] irq_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;
    logic [1:0]       win_id;
    logic             win_valid;
    logic             grant;

    assign rise     = irq_in & ~irq_d;
    assign eligible = pending & ~mask;

    prio_enc4 u_prio (
        .req   (eligible),
        .idx   (win_id),
        .valid (win_valid)
    );

    assign grant = (state == IDLE) && win_valid && !jmp_busy;

    // Clear of the granted source lands during REQ; a same-cycle edge re-sets it below.
    assign clr = (state == REQ) ? ({{(N_SRC-1){1'b0}}, 1'b1} << active_id) : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = REQ;
            REQ:     state_next = SERVICE;
            SERVICE: if (reti) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign interrupt  = (state == REQ);
    assign in_service = (state == SERVICE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            irq_d      <= '0;
            pending    <= '0;
            mask       <= '0;
            active_id  <= 2'd0;
            isr_vector <= VEC_BASE;
        end else begin
            state   <= state_next;
            irq_d   <= irq_in;
            pending <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (grant) begin
                active_id  <= win_id;
                isr_vector <= VEC_BASE + {14'd0, win_id};
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - randomized and directed bench for int_ctrl against a behavioural model
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        jmp_busy;
    logic        reti;
    logic        interrupt;
    logic [15:0] isr_vector;
    logic        in_service;
    logic [1:0]  active_id;
    logic [3:0]  pending;
    logic [3:0]  mask;

    int n_vec = 0;
    int n_err = 0;

    // Reference: pending set, mask, and "requesting now" / "serving" flags.
    bit [3:0] m_pend, m_irqd, m_mask;
    bit       m_req, m_serv;
    int       m_id;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .jmp_busy   (jmp_busy),
        .reti       (reti),
        .interrupt  (interrupt),
        .isr_vector (isr_vector),
        .in_service (in_service),
        .active_id  (active_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("interrupt", {31'd0, interrupt}, {31'd0, m_req});
        chk("in_service", {31'd0, in_service}, {31'd0, m_serv});
        chk("active_id", {30'd0, active_id}, m_id);
        chk("isr_vector", {16'd0, isr_vector}, 32'h00F0 + m_id);
        chk("pending", {28'd0, pending}, {28'd0, m_pend});
        chk("mask", {28'd0, mask}, {28'd0, m_mask});
    endtask

    task automatic model_reset();
        m_pend = '0; m_irqd = '0; m_mask = '0;
        m_req = 1'b0; m_serv = 1'b0; m_id = 0;
    endtask

    task automatic model_edge();
        bit [3:0] rise;
        bit [3:0] clr;
        bit [3:0] elig;
        rise = irq_in & ~m_irqd;
        clr  = '0;
        if (m_req) begin
            clr[m_id] = 1'b1;
            m_req  = 1'b0;
            m_serv = 1'b1;
        end else if (m_serv) begin
            if (reti) m_serv = 1'b0;
        end else begin
            elig = m_pend & ~m_mask;
            if (elig != 0 && !jmp_busy) begin
                for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
                m_req = 1'b1;
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        m_irqd = irq_in;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic step(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                        input logic busy, input logic rt);
        irq_in = irq; mask_we = mwe; mask_wdata = mwd; jmp_busy = busy; reti = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        irq_in = '0; mask_we = 0; mask_wdata = '0; jmp_busy = 0; reti = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_vector", {16'd0, isr_vector}, 32'h00F0);
        chk("rst_interrupt", {31'd0, interrupt}, 32'd0);

        // Single request on source 2
        step(4'b0100, 0, 0, 0, 0);
        chk("single_pend_set", {31'd0, pending[2]}, 32'd1);
        chk("single_no_int_N", {31'd0, interrupt}, 32'd0);
        step(4'b0100, 0, 0, 0, 0);
        chk("single_int_N1", {31'd0, interrupt}, 32'd1);
        chk("single_vec", {16'd0, isr_vector}, 32'h00F2);
        chk("single_id", {30'd0, active_id}, 32'd2);
        step(4'b0100, 0, 0, 0, 0);
        chk("single_int_drop", {31'd0, interrupt}, 32'd0);
        chk("single_pend_clr", {31'd0, pending[2]}, 32'd0);
        chk("single_in_svc", {31'd0, in_service}, 32'd1);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 1);
        chk("single_reti", {31'd0, in_service}, 32'd0);

        // Priority: 1 and 3 together
        step(4'b1010, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0);
        chk("prio_first_vec", {16'd0, isr_vector}, 32'h00F1);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0);
        chk("prio_second_int", {31'd0, interrupt}, 32'd1);
        chk("prio_second_vec", {16'd0, isr_vector}, 32'h00F3);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 1);

        // Mask holds back source 0 until cleared
        step(4'b0000, 1, 4'b0001, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        chk("mask_pend", {31'd0, pending[0]}, 32'd1);
        chk("mask_no_int", {31'd0, interrupt}, 32'd0);
        step(4'b0001, 1, 4'b0000, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        chk("unmask_int", {31'd0, interrupt}, 32'd1);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 1);

        // Stall on jmp_busy, then no nesting during service
        step(4'b0001, 0, 0, 1, 0);
        step(4'b0001, 0, 0, 1, 0);
        step(4'b0001, 0, 0, 1, 0);
        chk("stall_no_int", {31'd0, interrupt}, 32'd0);
        step(4'b0001, 0, 0, 0, 0);
        chk("stall_release", {31'd0, interrupt}, 32'd1);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        chk("nest_pend", {31'd0, pending[0]}, 32'd1);
        chk("nest_no_int", {31'd0, interrupt}, 32'd0);
        step(4'b0001, 0, 0, 0, 1);
        step(4'b0000, 0, 0, 0, 0);
        chk("nest_after_reti", {31'd0, interrupt}, 32'd1);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of service
        do_reset();
        step(4'b1001, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0);
        chk("mid_pre_svc", {31'd0, in_service}, 32'd1);
        chk("mid_pre_pend", {28'd0, pending}, 32'h8);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_svc_drop", {31'd0, in_service}, 32'd0);
        chk("mid_pend_zero", {28'd0, pending}, 32'd0);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 0, 0, 0, 0);
            chk("mid_no_int", {31'd0, interrupt}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
